// File: rtl/bus_sched_pkg.sv
// Shared types and defaults for the bus_sched round-robin bus scheduler.
package bus_sched_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OWN     = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam int NREQ_DEF    = 4;
   localparam int AW_DEF      = 8;
   localparam int TIMEOUT_DEF = 15;

   // Explicit wrap so that NREQ need not be a power of two.
   function automatic int next_ptr(input int idx, input int nreq);
      return (idx + 1 >= nreq) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/bus_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
   parameter  int N  = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          valid,
   output logic [PW-1:0] idx
);

   int j;

   // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer a latch.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      j     = 0;
      // Scan from the farthest offset down so the nearest requester is the last to win.
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (req[j]) begin
            valid = 1'b1;
            idx   = PW'(j);
         end
      end
   end

endmodule

// File: rtl/bus_sched.sv
// Round-robin owner of a shared tri-state address bus with a turnaround cycle between owners.
// Optional forced release after TIMEOUT ownership cycles: define BUS_SCHED_TIMEOUT_EN.
module bus_sched
   import bus_sched_pkg::*;
#(
   parameter int NREQ    = NREQ_DEF,
   parameter int AW      = AW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic             bus_ack,
   output logic [NREQ-1:0]  gnt,
   inout  wire  [AW-1:0]    address,
   output logic [NREQ-1:0]  done,
   output logic             busy,
   output logic             timeout_err
);

   localparam int PW = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
      $error("bus_sched: NREQ must be 2..8 and TIMEOUT at least 1");
   end

   state_t        state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] owner;
   logic [AW-1:0] addr_q;
   logic          oe;
   logic          pick_valid;
   logic [PW-1:0] pick_idx;
   logic          to_hit;

   rr_pick #(.N(NREQ)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign address = oe ? addr_q : 'z;

`ifdef BUS_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] to_cnt;

   // The cycle that would bring the count to TIMEOUT is the last allowed OWN cycle.
   assign to_hit = (state == OWN) && (to_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                     to_cnt <= '0;
      else if (state != OWN)          to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT)) to_cnt <= to_cnt + 1'b1;
   end
`else
   assign to_hit = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         gnt         <= '0;
         done        <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         oe          <= 1'b0;
         ptr         <= '0;
         owner       <= '0;
         addr_q      <= '0;
      end else begin
         done        <= '0;
         timeout_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pick_valid) begin
                  state  <= OWN;
                  owner  <= pick_idx;
                  gnt    <= NREQ'(1) << pick_idx;
                  addr_q <= req_addr[pick_idx*AW +: AW];
                  oe     <= 1'b1;
                  busy   <= 1'b1;
               end
            end
            OWN: begin
               // Ack wins over both abandon and timeout when they coincide.
               if (bus_ack || !req[owner] || to_hit) begin
                  state <= RELEASE;
                  gnt   <= '0;
                  oe    <= 1'b0;
                  busy  <= 1'b0;
                  ptr   <= PW'(next_ptr(int'(owner), NREQ));
                  if (bus_ack)          done        <= NREQ'(1) << owner;
                  else if (req[owner])  timeout_err <= 1'b1;
               end
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_sched.sv
// Self-checking bench for bus_sched: directed scenarios plus random traffic against a transfer-level model.
module tb_bus_sched;

   localparam int N  = 4;
   localparam int AW = 8;
   localparam int TO = 15;

   logic            clock = 1'b0;
   logic            reset;
   logic [N-1:0]    req;
   logic [N*AW-1:0] req_addr;
   logic            bus_ack;
   logic [N-1:0]    gnt, done;
   logic            busy, timeout_err;
   wire  [AW-1:0]   address;
   logic            tb_oe;

   // Bench holds the bus at zero whenever the scheduler should have let go.
   assign address = tb_oe ? '0 : 'z;

   logic [2:0]    req3;
   logic [3*AW-1:0] req_addr3;
   logic          ack3;
   logic [2:0]    gnt3, done3;
   logic          busy3, to3;
   wire  [AW-1:0] address3;

   always #5 clock = ~clock;

   bus_sched #(.NREQ(N), .AW(AW), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset), .req(req), .req_addr(req_addr), .bus_ack(bus_ack),
      .gnt(gnt), .address(address), .done(done), .busy(busy), .timeout_err(timeout_err)
   );

   bus_sched #(.NREQ(3), .AW(AW), .TIMEOUT(TO)) dut3 (
      .clock(clock), .reset(reset), .req(req3), .req_addr(req_addr3), .bus_ack(ack3),
      .gnt(gnt3), .address(address3), .done(done3), .busy(busy3), .timeout_err(to3)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: who owns the bus, whether we are in the turnaround, and whose turn is next.
   int            m_owner;
   bit            m_turn;
   int            m_ptr;
   int            m_cycles;
   logic [N-1:0]  e_gnt, e_done;
   logic          e_busy, e_to;
   logic [AW-1:0] e_addr;

   task automatic model_reset();
      m_owner = -1; m_turn = 0; m_ptr = 0; m_cycles = 0;
      e_gnt = '0; e_done = '0; e_busy = 0; e_to = 0; e_addr = '0;
      tb_oe = 1'b1;
   endtask

   task automatic model_step();
      bit hit;
      hit    = 0;
      e_done = '0;
      e_to   = 0;
      if (m_owner >= 0) begin
         m_cycles++;
`ifdef BUS_SCHED_TIMEOUT_EN
         hit = (m_cycles == TO);
`endif
         if (bus_ack || !req[m_owner] || hit) begin
            if (bus_ack)  e_done[m_owner] = 1'b1;
            else if (req[m_owner]) e_to = 1'b1;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_turn  = 1;
         end
      end else if (m_turn) begin
         m_turn = 0;
      end else begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (req[j]) begin
               m_owner  = j;
               m_cycles = 0;
               e_addr   = req_addr[j*AW +: AW];
               break;
            end
         end
      end
      e_gnt  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      e_busy = (m_owner >= 0);
      tb_oe  = !e_busy;
   endtask

   task automatic compare_all();
      check("gnt", 32'(gnt), 32'(e_gnt));
      check("done", 32'(done), 32'(e_done));
      check("busy", 32'(busy), 32'(e_busy));
      check("timeout_err", 32'(timeout_err), 32'(e_to));
      if (e_busy) check("address", 32'(address), 32'(e_addr));
      else        check("address_released", 32'(address), 32'(0));
   endtask

   // Inputs are driven at the falling edge, the model follows the rising edge, outputs are compared at the next falling edge.
   task automatic cycle(input logic [N-1:0] r, input logic a);
      req     = r;
      bus_ack = a;
      @(posedge clock);
      model_step();
      @(negedge clock);
      compare_all();
   endtask

   task automatic cycle3(input logic [2:0] r, input logic a);
      req3 = r;
      ack3 = a;
      @(posedge clock);
      @(negedge clock);
   endtask

   int owners[$];
   int times[$];
   int own_cnt;
   int done_cnt;

   initial begin
      reset = 1'b0; req = '0; bus_ack = 1'b0;
      req3 = '0; ack3 = 1'b0; req_addr3 = {8'h33, 8'h22, 8'h11};
      for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'($urandom_range(1, 255));
      model_reset();
      #2;
      compare_all();
      @(negedge clock);
      reset = 1'b1;

      // Single requester held for three ownership cycles, acked on the third.
      req_addr[2*AW +: AW] = 8'hA5;
      own_cnt = 0; done_cnt = 0;
      for (int c = 0; c < 5; c++) begin
         cycle(4'b0100, c == 3);
         if (gnt == 4'b0100 && address == 8'hA5) own_cnt++;
         if (done != '0) done_cnt++;
      end
      check("single_own_cycles", 32'(own_cnt), 32'd3);
      check("single_done_pulses", 32'(done_cnt), 32'd1);
      cycle(4'b1111, 1'b0);
      check("ptr_after_single", 32'(gnt), 32'b1000);
      cycle(4'b1111, 1'b1);
      cycle(4'b0000, 1'b0);

      // Everyone requesting with an immediate ack: strict rotation, one grant every three cycles.
      owners.delete(); times.delete();
      for (int c = 0; c < 15; c++) begin
         cycle(4'b1111, 1'b1);
         if (busy) begin
            for (int i = 0; i < N; i++) if (gnt[i]) owners.push_back(i);
            times.push_back(c);
         end
      end
      check("rotation_grants", 32'(owners.size()), 32'd5);
      for (int k = 0; k < owners.size() && k < 5; k++) begin
         check("rotation_order", 32'(owners[k]), 32'(k % N));
         check("rotation_spacing", 32'(times[k]), 32'(3 * k));
      end

      // Ack coinciding with a dropped request still completes the transfer.
      cycle(4'b0010, 1'b0);
      cycle(4'b0000, 1'b1);
      check("ack_and_drop_done", 32'(done), 32'b0010);
      cycle(4'b0000, 1'b0);
      // Abandon without ack: no completion, but the turn still moves on.
      cycle(4'b0010, 1'b0);
      cycle(4'b0000, 1'b0);
      check("abandon_no_done", 32'(done), 32'd0);
      cycle(4'b0000, 1'b0);
      cycle(4'b1111, 1'b0);
      check("after_abandon_gnt", 32'(gnt), 32'b0100);
      cycle(4'b1111, 1'b1);
      cycle(4'b0000, 1'b0);

      // Asynchronous reset in the middle of an ownership.
      req_addr[1*AW +: AW] = 8'h3C;
      cycle(4'b0010, 1'b0);
      check("pre_reset_gnt", 32'(gnt), 32'b0010);
      check("pre_reset_addr", 32'(address), 32'h3C);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check("async_reset_gnt", 32'(gnt), 32'd0);
      check("async_reset_busy", 32'(busy), 32'd0);
      check("async_reset_addr", 32'(address), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      cycle(4'b1110, 1'b0);
      check("post_reset_first", 32'(gnt), 32'b0010);
      cycle(4'b1111, 1'b1);
      cycle(4'b0000, 1'b0);

`ifdef BUS_SCHED_TIMEOUT_EN
      // Stuck owner forced off the bus, then an ack landing exactly on the last allowed cycle.
      for (int c = 0; c < 20; c++) cycle(4'b1001, 1'b0);
      cycle(4'b0000, 1'b1);
      cycle(4'b0000, 1'b0);
      cycle(4'b0000, 1'b0);
      for (int c = 0; c < 18; c++) cycle(4'b0001, c == 15);
      cycle(4'b0000, 1'b0);
      cycle(4'b0000, 1'b0);
`endif

      // Random traffic; addresses keep changing to show the owner's address is latched at grant.
      for (int c = 0; c < 800; c++) begin
         logic [N-1:0] r;
         for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'($urandom_range(1, 255));
         if (c < 400) begin
            for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 9) < 6);
            cycle(r, $urandom_range(0, 9) < 3);
         end else begin
            r = ($urandom_range(0, 19) == 0) ? N'($urandom) : '1;
            cycle(r, $urandom_range(0, 9) == 0);
         end
      end
      for (int c = 0; c < 3; c++) cycle(4'b0000, 1'b0);

      // Three requesters: wrap from pointer 2 back to index 0.
      cycle3(3'b010, 1'b0);
      check("n3_first_gnt", 32'(gnt3), 32'b010);
      cycle3(3'b010, 1'b1);
      check("n3_first_done", 32'(done3), 32'b010);
      cycle3(3'b000, 1'b0);
      cycle3(3'b011, 1'b0);
      check("n3_wrap_gnt", 32'(gnt3), 32'b001);
      check("n3_wrap_addr", 32'(address3), 32'h11);
      cycle3(3'b011, 1'b1);
      cycle3(3'b000, 1'b0);
      cycle3(3'b011, 1'b0);
      check("n3_after_wrap_gnt", 32'(gnt3), 32'b010);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
